// File: rtl/demux4_scheduler.sv
// demux4_scheduler: registered 1-to-4 demux with valid/ready flow control,
// directed or round-robin destination selection, and a saturating drop counter.
module demux4_scheduler #(
    parameter int W    = 1,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    I,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic            mode,
    input  logic            s1,
    input  logic            s0,
    input  logic [3:0]      en,
    output logic [W-1:0]    y0,
    output logic [W-1:0]    y1,
    output logic [W-1:0]    y2,
    output logic [W-1:0]    y3,
    output logic [3:0]      v,
    input  logic [3:0]      rdy,
    output logic [1:0]      sel_q,
    output logic            busy,
    output logic [CNTW-1:0] drop_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [W-1:0] data_q;
    logic [1:0]   last_q, base, rr_dest, dest;
    logic         acc, dlv, drop, take;
    assign busy    = state == HOLD;
    assign dlv     = busy & rdy[sel_q];
    assign i_ready = !busy | rdy[sel_q];
    assign acc     = i_valid & i_ready;
    // A same-cycle delivery advances the rotation before the new word picks its channel
    assign base    = dlv ? sel_q : last_q;
    assign rr_dest = en[base + 2'd1] ? base + 2'd1 :
                     en[base + 2'd2] ? base + 2'd2 :
                     en[base + 2'd3] ? base + 2'd3 : base;
    assign dest    = mode ? rr_dest : {s1, s0};
    assign drop    = acc & (mode ? en == 4'b0000 : !en[{s1, s0}]);
    assign take    = acc & !drop;
    assign v       = busy ? 4'b0001 << sel_q : 4'b0000;
    assign y0      = v[0] ? data_q : '0;
    assign y1      = v[1] ? data_q : '0;
    assign y2      = v[2] ? data_q : '0;
    assign y3      = v[3] ? data_q : '0;
    always_comb begin
        state_n = take ? HOLD : dlv ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            if (dlv) last_q <= sel_q;
            if (take) begin
                data_q <= I;
                sel_q  <= dest;
            end
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux4_scheduler.sv
// tb_demux4_scheduler: directed checks of demux4_scheduler with W=8, CNTW=2.
module tb_demux4_scheduler;
    logic       clk = 0, rst = 1;
    logic [7:0] I = 0;
    logic       i_valid = 0, i_ready, mode = 0, s1 = 0, s0 = 0, busy;
    logic [3:0] en = 0, v, rdy = 0;
    logic [7:0] y0, y1, y2, y3;
    logic [1:0] sel_q, drop_cnt;
    int n_run = 0, n_fail = 0;

    demux4_scheduler #(.W(8), .CNTW(2)) dut (
        .clk(clk), .rst(rst), .I(I), .i_valid(i_valid), .i_ready(i_ready),
        .mode(mode), .s1(s1), .s0(s0), .en(en), .y0(y0), .y1(y1), .y2(y2),
        .y3(y3), .v(v), .rdy(rdy), .sel_q(sel_q), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic ychk(input string tag, input logic [1:0] ch, input logic [7:0] d);
        logic [7:0] exp_y[4];
        for (int k = 0; k < 4; k++) exp_y[k] = (k == int'(ch)) ? d : 8'h00;
        chk({tag, "_v"}, v, 4'b0001 << ch);
        chk({tag, "_sel"}, sel_q, ch);
        chk({tag, "_y0"}, y0, exp_y[0]);
        chk({tag, "_y1"}, y1, exp_y[1]);
        chk({tag, "_y2"}, y2, exp_y[2]);
        chk({tag, "_y3"}, y3, exp_y[3]);
    endtask

    logic [1:0] rr_full[5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] rr_sparse[4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [1:0] sat_seq[5]   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        step();
        chk("rst_v", v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irdy", i_ready, 1);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_sel", sel_q, 0);
        rst = 0;

        // directed, no stall
        mode = 0; {s1, s0} = 2'b10; I = 8'h01; i_valid = 1; en = 4'b1111; rdy = 4'b1111;
        step();
        i_valid = 0;
        ychk("dir", 2'd2, 8'h01);
        chk("dir_busy", busy, 1);
        step();
        chk("dir_idle_v", v, 0);
        chk("dir_idle_busy", busy, 0);

        // round-robin, full mask
        do_reset();
        mode = 1; en = 4'b1111; rdy = 4'b1111; i_valid = 1;
        for (int k = 0; k < 5; k++) begin
            I = 8'h10 + 8'(k);
            chk("rr_full_irdy", i_ready, 1);
            step();
            ychk("rr_full", rr_full[k], 8'h10 + 8'(k));
        end

        // round-robin, sparse mask continuing from last channel 0
        en = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            I = 8'h20 + 8'(k);
            step();
            ychk("rr_sparse", rr_sparse[k], 8'h20 + 8'(k));
        end
        en = 4'b0000;
        step();
        chk("rr_drop1_cnt", drop_cnt, 1);
        chk("rr_drop1_v", v, 0);
        step();
        chk("rr_drop2_cnt", drop_cnt, 2);
        chk("rr_drop2_v", v, 0);
        i_valid = 0;

        // backpressure then same-cycle hand-off
        do_reset();
        mode = 0; en = 4'b1111; rdy = 4'b1101; {s1, s0} = 2'b01; I = 8'h5A; i_valid = 1;
        step();
        I = 8'h77; {s1, s0} = 2'b11;
        for (int k = 0; k < 3; k++) begin
            ychk("bp_hold", 2'd1, 8'h5A);
            chk("bp_irdy", i_ready, 0);
            step();
        end
        rdy = 4'b1111;
        #1 chk("bp_irdy_up", i_ready, 1);
        step();
        i_valid = 0;
        ychk("bp_handoff", 2'd3, 8'h77);
        step();
        chk("bp_done_v", v, 0);

        // drop saturation, CNTW=2
        do_reset();
        mode = 0; en = 4'b1110; {s1, s0} = 2'b00; I = 8'hAA; i_valid = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sat_cnt", drop_cnt, sat_seq[k]);
            chk("sat_busy", busy, 0);
        end

        // asynchronous reset while holding a word for channel 2
        {s1, s0} = 2'b10; I = 8'hC3; rdy = 4'b0000;
        step();
        i_valid = 0;
        ychk("ar_pre", 2'd2, 8'hC3);
        #2 rst = 1;
        #1;
        chk("ar_v", v, 0);
        chk("ar_y2", y2, 0);
        chk("ar_busy", busy, 0);
        chk("ar_irdy", i_ready, 1);
        chk("ar_drop", drop_cnt, 0);
        step();
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_scheduler.md
# demux4_scheduler

Registered 1-to-4 demultiplexer controller that accepts a valid/ready input stream and steers each word to one of four output channels. Each output channel has its own valid/ready handshake. Destination comes either from explicit select lines (directed mode) or from a round-robin pointer over an enable mask. It sits between a single producer and four consumers and replaces the bare combinational demux wherever flow control or automatic channel rotation is needed.

## Interface
Parameters:
- W, 1, data width of I and y0..y3
- CNTW, 8, width of the saturating drop counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- I  in  W  input data word
- i_valid  in  1  producer has a word on I
- i_ready  out  1  block accepts a word this cycle
- mode  in  1  0 = directed (destination {s1,s0}); 1 = round-robin
- s1, s0  in  1 each  directed-mode destination, sampled on accept
- en  in  4  channel enable mask, bit k enables channel k
- y0, y1, y2, y3  out  W each  channel data
- v  out  4  per-channel valid, one-hot or zero
- rdy  in  4  per-channel consumer ready
- sel_q  out  2  destination of the held word
- busy  out  1  a word is held
- drop_cnt  out  CNTW  count of discarded words, saturating

## Operation
- States:
  - IDLE: buffer empty.
  - HOLD: one word held in data_q for channel sel_q.
- Accept: acc = i_valid & i_ready.
  - i_ready = (state==IDLE) | rdy[sel_q]. A HOLD word may be delivered and a new word accepted in the same cycle.
- Destination on accept:
  - mode=0: dest = {s1,s0}.
  - mode=1: dest = first enabled channel searching circularly from last_q+1 (ties impossible; order last_q+1, +2, +3, +0).
- Drop: if mode=0 and en[dest]=0, or mode=1 and en=4'b0000, the word is discarded.
  - drop_cnt increments, saturating at 2^CNTW-1.
  - No state change except a pending delivery completing that cycle.
- On accept without drop: data_q<=I, sel_q<=dest, state<=HOLD.
- In HOLD:
  - v[sel_q]=1 and y{sel_q}=data_q.
  - All other v bits are 0 and all other y outputs are 0 (AND-gated, same as the plain demux).
- Delivery: state==HOLD & rdy[sel_q]. Sets last_q<=sel_q. Next state:
  - HOLD if a non-dropped word is accepted the same cycle;
  - otherwise IDLE.
- Round-robin dest on a same-cycle accept is computed from the sel_q being delivered.
- Destination is latched. Changes to en, mode, s1/s0 while in HOLD do not affect the held word; it is delivered even if its channel is disabled mid-hold.
- rdy bits of non-selected channels are ignored.
- busy = (state==HOLD).

## Timing
- Reset values: state=IDLE, data_q=0, sel_q=0, last_q=3 (first round-robin word goes to channel 0), drop_cnt=0, v=0, y0..y3=0, busy=0, i_ready=1.
- Reset asserted mid-HOLD: the held word is lost, and all outputs go to their reset values immediately (asynchronously).
- Latency: a word accepted at edge N appears on y/v from edge N through the delivery edge. One cycle from I to y.
- Throughput: 1 word/cycle when the selected consumer holds rdy high.
- Backpressure: while in HOLD with rdy[sel_q]=0, i_ready=0 and y/v/sel_q are held stable.
- i_ready depends combinationally on rdy. No combinational path exists from I, s1/s0, or en to any output.

## Test plan
- Reset during HOLD: hold a word for channel 2, assert rst without a clock edge -> v=0000, y*=0, busy=0, i_ready=1 immediately; drop_cnt=0.
- Directed, no stall: mode=0, s1s0=10, I=1, i_valid=1, en=1111, rdy=1111 for one cycle -> next cycle v=0100, y2=1, sel_q=2; following edge -> IDLE, v=0000.
- Round-robin full mask: mode=1, en=1111, rdy=1111, five back-to-back words (one per cycle) -> channels 0,1,2,3,0 on consecutive cycles, i_ready=1 throughout.
- Round-robin sparse mask: en=1010, four words -> channels 1,3,1,3. Then en=0000 and two words -> drop_cnt=2, no v asserted.
- Backpressure plus same-cycle hand-off: word to ch1 with rdy[1]=0 for 3 cycles -> i_ready=0, y1/v stable. Raise rdy[1] with i_valid=1 and s1s0=11 -> ch1 delivered and the new word held for ch3 on the same edge.
- Drop saturation with CNTW=2: mode=0, en=1110, five words to channel 0 -> drop_cnt sequence 1,2,3,3,3; busy stays 0.
